uart_tx_fifo_p: RTL and testbench



---
 rtl/uart_tx_fifo_p.sv | 205 ++++++++++++++++++++
 tb/tb_uart_tx_fifo_p.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_p.sv
// UART transmitter with a synchronous TX FIFO, runtime frame format, break generation
// and back-to-back frames. All outputs are registered.
module uart_tx_fifo_p #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned FIFO_AW = 4,
  parameter int unsigned DIV_W   = 16
) (
  input  logic               clk,
  input  logic               tx_rstn,
  input  logic [DIV_W-1:0]   baud_div,
  input  logic [3:0]         data_length,
  input  logic               parity_en,
  input  logic [1:0]         parity_sel,
  input  logic [1:0]         stop_sel,
  input  logic               break_req,
  input  logic               fifo_write,
  input  logic [DATA_W-1:0]  fifo_wdata,
  input  logic               fifo_clear,
  output logic               tx,
  output logic               tx_work,
  output logic               tx_done,
  output logic [FIFO_AW:0]   tx_fifo_cnt,
  output logic               tx_fifo_full,
  output logic               tx_fifo_empty,
  output logic               tx_overflow
);
  localparam int unsigned DEPTH = 2 ** FIFO_AW;
  localparam int unsigned CW    = DIV_W + 1;
  localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   cnt_q, cnt_d;
  logic               full_q, empty_q, ovf_q;
  logic               wr_en, pop;

  state_t             state_q;
  logic [CW-1:0]      clk_cnt_q, b_q, stop_len_q;
  logic [3:0]         bit_idx_q, len_q;
  logic [DATA_W-1:0]  shift_q;
  logic               par_en_q, par_bit_q;
  logic               tx_q, work_q, done_q;

  logic [CW-1:0]      b_cfg, stop_cfg;
  logic [3:0]         len_cfg;
  logic [DATA_W-1:0]  word_masked;
  logic               par_cfg;
  logic               bit_end, stop_end;

  // Frame format resolved from the live config; captured only when a word is popped
  always_comb begin
    b_cfg    = (baud_div < DIV_W'(2)) ? CW'(2) : CW'(baud_div);
    stop_cfg = b_cfg;
    unique case (stop_sel)
      2'b00:   stop_cfg = b_cfg;
      2'b01:   stop_cfg = b_cfg + (b_cfg >> 1);
      default: stop_cfg = b_cfg << 1;
    endcase
    len_cfg = (data_length >= 4'd5 && data_length <= 4'(DATA_W)) ? data_length : 4'(DATA_W);
    word_masked = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      word_masked[i] = mem_q[rd_ptr_q][i] & (i < 32'(len_cfg));
    end
    par_cfg = 1'b0;
    unique case (parity_sel)
      2'b00:   par_cfg = ~^word_masked;
      2'b01:   par_cfg = ^word_masked;
      2'b10:   par_cfg = 1'b1;
      default: par_cfg = 1'b0;
    endcase
  end

  always_comb begin
    bit_end  = (clk_cnt_q == b_q - CW'(1));
    stop_end = (clk_cnt_q == stop_len_q - CW'(1));
    pop      = ~empty_q & ~break_req &
               ((state_q == IDLE) | ((state_q == STOP) & stop_end));
    wr_en    = fifo_write & ~full_q & ~fifo_clear;
    if (fifo_clear) cnt_d = '0;
    else            cnt_d = cnt_q + {{FIFO_AW{1'b0}}, wr_en} - {{FIFO_AW{1'b0}}, pop};
  end

  always_ff @(posedge clk) begin
    if (!tx_rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      ovf_q   <= fifo_write & full_q;
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == DEPTH_C);
      empty_q <= (cnt_d == '0);
      if (fifo_clear) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= fifo_wdata;
  end

  always_ff @(posedge clk) begin
    if (!tx_rstn) begin
      state_q    <= IDLE;
      clk_cnt_q  <= '0;
      bit_idx_q  <= '0;
      b_q        <= '0;
      stop_len_q <= '0;
      len_q      <= '0;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      tx_q       <= 1'b1;
      work_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      clk_cnt_q <= clk_cnt_q + CW'(1);
      case (state_q)
        IDLE: begin
          clk_cnt_q <= '0;
          if (break_req) begin
            state_q    <= BREAK;
            tx_q       <= 1'b0;
            work_q     <= 1'b1;
            b_q        <= b_cfg;
            stop_len_q <= b_cfg;
          end
        end
        START: if (bit_end) begin
          state_q   <= DATA;
          clk_cnt_q <= '0;
          bit_idx_q <= '0;
          tx_q      <= shift_q[0];
          shift_q   <= shift_q >> 1;
        end
        DATA: if (bit_end) begin
          clk_cnt_q <= '0;
          if (bit_idx_q == len_q - 4'd1) begin
            bit_idx_q <= '0;
            state_q   <= par_en_q ? PARITY : STOP;
            tx_q      <= par_en_q ? par_bit_q : 1'b1;
          end else begin
            bit_idx_q <= bit_idx_q + 4'd1;
            tx_q      <= shift_q[0];
            shift_q   <= shift_q >> 1;
          end
        end
        PARITY: if (bit_end) begin
          state_q   <= STOP;
          clk_cnt_q <= '0;
          tx_q      <= 1'b1;
        end
        STOP: begin
          if (clk_cnt_q == stop_len_q - CW'(2)) done_q <= 1'b1;
          if (stop_end) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            work_q    <= 1'b0;
          end
        end
        BREAK: begin
          clk_cnt_q <= '0;
          if (!break_req) begin
            state_q <= STOP;
            tx_q    <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
      // A pop (from IDLE or the last stop clock) overrides the state-local choice above
      if (pop) begin
        state_q    <= START;
        clk_cnt_q  <= '0;
        bit_idx_q  <= '0;
        tx_q       <= 1'b0;
        work_q     <= 1'b1;
        shift_q    <= word_masked;
        len_q      <= len_cfg;
        par_en_q   <= parity_en;
        par_bit_q  <= par_cfg;
        b_q        <= b_cfg;
        stop_len_q <= stop_cfg;
      end
    end
  end

  assign tx            = tx_q;
  assign tx_work       = work_q;
  assign tx_done       = done_q;
  assign tx_fifo_cnt   = cnt_q;
  assign tx_fifo_full  = full_q;
  assign tx_fifo_empty = empty_q;
  assign tx_overflow   = ovf_q;
endmodule

// File: tb/tb_uart_tx_fifo_p.sv
// Scoreboard bench for uart_tx_fifo_p: stimulus pushes expected frames, a monitor
// captures each frame on the line and compares its waveform, tx_done and tx_work.
module tb_uart_tx_fifo_p;
  logic        clk;
  logic        tx_rstn;
  logic [15:0] baud_div;
  logic [3:0]  data_length;
  logic        parity_en;
  logic [1:0]  parity_sel;
  logic [1:0]  stop_sel;
  logic        break_req;
  logic        fifo_write;
  logic [7:0]  fifo_wdata;
  logic        fifo_clear;
  logic        tx, tx_work, tx_done, tx_fifo_full, tx_fifo_empty, tx_overflow;
  logic [4:0]  tx_fifo_cnt;

  uart_tx_fifo_p #(.DATA_W(8), .FIFO_AW(4), .DIV_W(16)) dut (
    .clk(clk), .tx_rstn(tx_rstn), .baud_div(baud_div), .data_length(data_length),
    .parity_en(parity_en), .parity_sel(parity_sel), .stop_sel(stop_sel),
    .break_req(break_req), .fifo_write(fifo_write), .fifo_wdata(fifo_wdata),
    .fifo_clear(fifo_clear), .tx(tx), .tx_work(tx_work), .tx_done(tx_done),
    .tx_fifo_cnt(tx_fifo_cnt), .tx_fifo_full(tx_fifo_full),
    .tx_fifo_empty(tx_fifo_empty), .tx_overflow(tx_overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [7:0] data;
    int         n;
    bit         pen;
    bit         pbit;
    int         b;
    int         len;
  } frame_t;

  frame_t exp_q[$];
  int     n_chk = 0;
  int     n_pass = 0;
  int     frames_seen = 0;
  bit     mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic void push(input logic [7:0] d, input int n, input bit pen,
                               input bit pb, input int b, input int len);
    frame_t f;
    f.data = d; f.n = n; f.pen = pen; f.pbit = pb; f.b = b; f.len = len;
    exp_q.push_back(f);
  endfunction

  // Monitor: a 1->0 line transition while enabled marks a start bit
  initial begin : monitor
    frame_t f;
    bit     prev_tx;
    int     werr, derr, kerr, bi;
    logic   e;
    prev_tx = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en && prev_tx && tx === 1'b0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 32'd1, 32'd0);
        end else begin
          f = exp_q.pop_front();
          werr = 0; derr = 0; kerr = 0;
          for (int k = 0; k < f.len; k++) begin
            if (k > 0) @(negedge clk);
            bi = k / f.b;
            if (bi == 0)                       e = 1'b0;
            else if (bi <= f.n)                e = f.data[bi-1];
            else if (f.pen && bi == f.n + 1)   e = f.pbit;
            else                               e = 1'b1;
            if (tx !== e) werr++;
            if (tx_done !== (k == f.len - 1)) derr++;
            if (tx_work !== 1'b1) kerr++;
          end
          chk("frame_wave_errs", werr, 0);
          chk("frame_done_errs", derr, 0);
          chk("frame_work_errs", kerr, 0);
          frames_seen++;
        end
      end
      prev_tx = (tx === 1'b1);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed so far", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  task automatic write_word(input logic [7:0] d);
    @(negedge clk); fifo_write = 1'b1; fifo_wdata = d;
    @(negedge clk); fifo_write = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && tx_work === 1'b0) begin ok = 1'b1; break; end
    end
    chk(name, ok, 1);
  endtask

  initial begin : stim
    int hi, gaps, tgt;
    tx_rstn = 1'b0; baud_div = 16'd4; data_length = 4'd8; parity_en = 1'b0;
    parity_sel = 2'b00; stop_sel = 2'b00; break_req = 1'b0; fifo_write = 1'b0;
    fifo_wdata = 8'h00; fifo_clear = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_work", tx_work, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_ovf", tx_overflow, 0);
    chk("rst_cnt", tx_fifo_cnt, 0);
    chk("rst_empty", tx_fifo_empty, 1);
    chk("rst_full", tx_fifo_full, 0);
    tx_rstn = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // 8N1, 0xA5: 0,1,0,1,0,0,1,0,1,1 at 4 clocks per bit
    push(8'hA5, 8, 0, 0, 4, 40);
    write_word(8'hA5);
    chk("lat_cnt_e0", tx_fifo_cnt, 1);
    chk("lat_work_e0", tx_work, 0);
    @(negedge clk);
    chk("lat_tx_e1", tx, 0);
    chk("lat_work_e1", tx_work, 1);
    chk("lat_cnt_e1", tx_fifo_cnt, 0);
    wait_idle("idle_8n1");
    chk("post_work", tx_work, 0);

    // 8O1 / 8E1 on 0x53 (four ones)
    parity_en = 1'b1; parity_sel = 2'b00;
    push(8'h53, 8, 1, 1, 4, 44);
    write_word(8'h53);
    wait_idle("idle_8o1");
    parity_sel = 2'b01;
    push(8'h53, 8, 1, 0, 4, 44);
    write_word(8'h53);
    wait_idle("idle_8e1");

    // 7 bits, mark parity, 1.5 stop (6 clocks)
    data_length = 4'd7; parity_sel = 2'b10; stop_sel = 2'b01;
    push(8'hFF, 7, 1, 1, 4, 42);
    write_word(8'hFF);
    wait_idle("idle_7m15");

    // divisor 1 -> 2, length 4 -> 8, even parity, two stop bits
    baud_div = 16'd1; data_length = 4'd4; parity_sel = 2'b01; stop_sel = 2'b10;
    push(8'h3C, 8, 1, 0, 2, 24);
    write_word(8'h3C);
    wait_idle("idle_clamp");

    baud_div = 16'd4; data_length = 4'd8; parity_en = 1'b0; stop_sel = 2'b00;

    // Break while filling the FIFO past full
    mon_en = 1'b0;
    @(negedge clk); break_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); fifo_write = 1'b1; fifo_wdata = 8'(i * 37 + 5);
      push(8'(i * 37 + 5), 8, 0, 0, 4, 40);
    end
    @(negedge clk);
    chk("brk_cnt16", tx_fifo_cnt, 16);
    chk("brk_full", tx_fifo_full, 1);
    chk("brk_no_ovf", tx_overflow, 0);
    fifo_wdata = 8'hEE;
    @(negedge clk); fifo_write = 1'b0;
    chk("brk_ovf", tx_overflow, 1);
    chk("brk_cnt_hold", tx_fifo_cnt, 16);
    chk("brk_tx_low", tx, 0);
    chk("brk_work", tx_work, 1);
    @(negedge clk);
    chk("brk_ovf_pulse", tx_overflow, 0);
    repeat (3) @(negedge clk);
    chk("brk_tx_held", tx, 0);
    break_req = 1'b0;
    mon_en = 1'b1;
    hi = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx === 1'b1) hi++;
      else break;
    end
    chk("brk_stop_clocks", hi, 4);
    tgt = frames_seen + 16;
    gaps = 0;
    for (int i = 0; i < 1000; i++) begin
      if (frames_seen >= tgt) break;
      if (tx_work !== 1'b1) gaps++;
      @(negedge clk);
    end
    chk("b2b_frames", frames_seen, tgt);
    chk("b2b_gaps", gaps, 0);
    wait_idle("idle_b2b");
    chk("b2b_empty", tx_fifo_empty, 1);

    // Write + clear in the same cycle with 3 words queued behind a frame in flight
    push(8'hC3, 8, 0, 0, 4, 40);
    @(negedge clk); fifo_write = 1'b1; fifo_wdata = 8'hC3;
    @(negedge clk); fifo_wdata = 8'h11;
    @(negedge clk); fifo_wdata = 8'h22;
    @(negedge clk); fifo_wdata = 8'h33;
    @(negedge clk);
    chk("clr_pre_cnt", tx_fifo_cnt, 3);
    fifo_clear = 1'b1; fifo_wdata = 8'h44;
    @(negedge clk); fifo_write = 1'b0; fifo_clear = 1'b0;
    chk("clr_cnt", tx_fifo_cnt, 0);
    chk("clr_empty", tx_fifo_empty, 1);
    chk("clr_work", tx_work, 1);
    wait_idle("idle_clr");
    chk("clr_end_cnt", tx_fifo_cnt, 0);

    // Reset mid-DATA, then a clean restart
    mon_en = 1'b0;
    write_word(8'h96);
    repeat (8) @(negedge clk);
    chk("rr_pre_work", tx_work, 1);
    tx_rstn = 1'b0;
    @(negedge clk); tx_rstn = 1'b1;
    chk("rr_tx", tx, 1);
    chk("rr_work", tx_work, 0);
    chk("rr_cnt", tx_fifo_cnt, 0);
    repeat (2) @(negedge clk);
    chk("rr_tx_idle", tx, 1);
    mon_en = 1'b1;
    @(negedge clk);
    push(8'h5A, 8, 0, 0, 4, 40);
    write_word(8'h5A);
    chk("rr_lat_cnt", tx_fifo_cnt, 1);
    @(negedge clk);
    chk("rr_lat_tx", tx, 0);
    chk("rr_lat_work", tx_work, 1);
    wait_idle("idle_rr");

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
